pong_match_seq: RTL and testbench

PONG_MATCH_SEQ -- requirements
Module: pong_match_seq

---
 rtl/pong_match_seq_if.sv | 26 ++
 rtl/pong_match_seq.sv | 118 +++++++++++
 tb/tb_pong_match_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pong_match_seq_if.sv
// pong_match_seq_if: control strobes into and status out of the pong match sequencer
// master drives tick/start_btn/miss_p1/miss_p2 and observes the game status;
// slave (the sequencer) consumes the strobes and drives state, serve/ball control, blink, scores, winner.
interface pong_match_seq_if;
  logic        tick;
  logic        start_btn;
  logic        miss_p1;
  logic        miss_p2;
  logic [2:0]  state;
  logic        serve_load;
  logic        server;
  logic        ball_run;
  logic        blink;
  logic [3:0]  score_p1;
  logic [3:0]  score_p2;
  logic [13:0] score_disp;
  logic [1:0]  winner;
  modport master (
    output tick, start_btn, miss_p1, miss_p2,
    input  state, serve_load, server, ball_run, blink, score_p1, score_p2, score_disp, winner
  );
  modport slave (
    input  tick, start_btn, miss_p1, miss_p2,
    output state, serve_load, server, ball_run, blink, score_p1, score_p2, score_disp, winner
  );
endinterface

// File: rtl/pong_match_seq.sv
// pong_match_seq: match sequencer for pong (serve, rally, point, game over) with scoring
// Ports: CLK system clock; RSTn asynchronous active-low reset;
// bus (slave): tick game-step strobe, start_btn raw async button, miss_p1/miss_p2 edge-miss pulses,
// state FSM code, serve_load serve pulse, server, ball_run, blink, score_p1/score_p2,
// score_disp (score_p1*100+score_p2), winner (0 none, 1 p1, 2 p2).
module pong_match_seq #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 8,
  parameter int POINT_TICKS = 16
) (
  input logic CLK,
  input logic RSTn,
  pong_match_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, RALLY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
  localparam int CMAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] S_LAST = CW'(SERVE_TICKS - 1);
  localparam logic [CW-1:0] P_LAST = CW'(POINT_TICKS - 1);
  localparam logic [3:0] WS = 4'(WIN_SCORE);
  state_t st;
  logic s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [3:0] sp1, sp2;
  logic srv, run, ld, bl;
  logic [1:0] win;
  logic [13:0] disp;
  logic start_ev, p1_won, p2_won;
  always_comb begin
    start_ev = s2 & ~s3;
    p1_won = sp1 == WS;
    p2_won = sp2 == WS;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      st <= IDLE;
      {s1, s2, s3} <= 3'b000;
      cnt <= '0;
      sp1 <= 4'd0;
      sp2 <= 4'd0;
      srv <= 1'b0;
      run <= 1'b0;
      ld <= 1'b0;
      bl <= 1'b0;
      win <= 2'd0;
      disp <= 14'd0;
    end else begin
      {s1, s2, s3} <= {bus.start_btn, s1, s2};
      ld <= 1'b0;
      disp <= 14'(sp1) * 14'd100 + 14'(sp2);
      case (st)
        IDLE, OVER:
          if (start_ev) begin
            st <= SERVE;
            ld <= 1'b1;
            cnt <= '0;
            sp1 <= 4'd0;
            sp2 <= 4'd0;
            srv <= 1'b0;
            win <= 2'd0;
          end
        SERVE:
          if (bus.tick) begin
            if (cnt == S_LAST) begin
              st <= RALLY;
              run <= 1'b1;
              cnt <= '0;
            end else
              cnt <= cnt + CW'(1);
          end
        RALLY:
          // a double miss is treated as a glitch and ignored
          if (bus.miss_p1 ^ bus.miss_p2) begin
            st <= POINT;
            run <= 1'b0;
            bl <= 1'b0;
            cnt <= '0;
            srv <= bus.miss_p2;
            if (bus.miss_p1)
              sp2 <= p2_won ? sp2 : sp2 + 4'd1;
            else
              sp1 <= p1_won ? sp1 : sp1 + 4'd1;
          end
        POINT:
          if (bus.tick) begin
            if (cnt == P_LAST) begin
              bl <= 1'b0;
              cnt <= '0;
              if (p1_won | p2_won) begin
                st <= OVER;
                win <= p1_won ? 2'd1 : 2'd2;
              end else begin
                st <= SERVE;
                ld <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
              bl <= ~bl;
            end
          end
        default: begin
          st <= IDLE;
          run <= 1'b0;
          bl <= 1'b0;
          cnt <= '0;
        end
      endcase
    end
  assign bus.state = st;
  assign bus.serve_load = ld;
  assign bus.server = srv;
  assign bus.ball_run = run;
  assign bus.blink = bl;
  assign bus.score_p1 = sp1;
  assign bus.score_p2 = sp2;
  assign bus.score_disp = disp;
  assign bus.winner = win;
endmodule

// File: tb/tb_pong_match_seq.sv
// tb_pong_match_seq: table vectors plus scripted games checked through an expectation queue
module tb_pong_match_seq;
  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_RALLY = 3'd2, S_POINT = 3'd3, S_OVER = 3'd4;
  localparam logic [3:0] WS = 4'd5;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;
  pong_match_seq_if bus();
  pong_match_seq #(.WIN_SCORE(5), .SERVE_TICKS(8), .POINT_TICKS(16)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));
  typedef struct {
    string nm;
    logic [2:0] st;
    logic [3:0] p1, p2;
    logic srv, run, ld, bl;
    logic [1:0] win;
    logic [13:0] disp;
  } exp_t;
  typedef struct {
    logic tk, sb, m1, m2;
    exp_t e;
  } vec_t;
  exp_t q[$];
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  function automatic exp_t mk(string nm, logic [2:0] st, logic [3:0] p1, logic [3:0] p2, logic srv, logic run,
                              logic ld, logic bl, logic [1:0] win, logic [13:0] disp);
    exp_t e;
    e.nm = nm; e.st = st; e.p1 = p1; e.p2 = p2; e.srv = srv; e.run = run;
    e.ld = ld; e.bl = bl; e.win = win; e.disp = disp;
    return e;
  endfunction
  function automatic vec_t mv(logic tk, logic sb, logic m1, logic m2, exp_t e);
    vec_t v;
    v.tk = tk; v.sb = sb; v.m1 = m1; v.m2 = m2; v.e = e;
    return v;
  endfunction
  task automatic compare_front();
    exp_t e;
    e = q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.score_p1 !== e.p1 || bus.score_p2 !== e.p2 || bus.server !== e.srv ||
        bus.ball_run !== e.run || bus.serve_load !== e.ld || bus.blink !== e.bl || bus.winner !== e.win ||
        bus.score_disp !== e.disp) begin
      errors++;
      $display("FAIL %s: got st=%0d p1=%0d p2=%0d srv=%0b run=%0b ld=%0b bl=%0b win=%0d disp=%0d, want st=%0d p1=%0d p2=%0d srv=%0b run=%0b ld=%0b bl=%0b win=%0d disp=%0d",
               e.nm, bus.state, bus.score_p1, bus.score_p2, bus.server, bus.ball_run, bus.serve_load, bus.blink,
               bus.winner, bus.score_disp, e.st, e.p1, e.p2, e.srv, e.run, e.ld, e.bl, e.win, e.disp);
    end
  endtask
  task automatic check_now(input exp_t e);
    q.push_back(e);
    compare_front();
  endtask
  task automatic cyc(input logic tk, input logic m1, input logic m2, input exp_t e);
    bus.tick = tk;
    bus.miss_p1 = m1;
    bus.miss_p2 = m2;
    q.push_back(e);
    @(posedge CLK);
    #1;
    bus.tick = 1'b0;
    bus.miss_p1 = 1'b0;
    bus.miss_p2 = 1'b0;
    compare_front();
  endtask
  task automatic serve_to_rally(input logic [3:0] p1, input logic [3:0] p2, input logic srv);
    logic [13:0] d;
    d = 14'(100 * p1 + p2);
    cyc(0, 0, 0, mk("serve_hold", S_SERVE, p1, p2, srv, 0, 0, 0, 0, d));
    for (int k = 1; k < 8; k++) cyc(1, 0, 0, mk("serve_tick", S_SERVE, p1, p2, srv, 0, 0, 0, 0, d));
    cyc(1, 0, 0, mk("serve_release", S_RALLY, p1, p2, srv, 1, 0, 0, 0, d));
  endtask
  task automatic point_tail(input logic [3:0] p1, input logic [3:0] p2, input logic srv, input logic over);
    logic [13:0] d;
    d = 14'(100 * p1 + p2);
    for (int k = 1; k < 16; k++) begin
      cyc(1, 0, 0, mk("blink_tick", S_POINT, p1, p2, srv, 0, 0, 1'(k % 2), 0, d));
      if (k == 1) cyc(0, 0, 0, mk("blink_hold", S_POINT, p1, p2, srv, 0, 0, 1, 0, d));
    end
    cyc(1, 0, 0, mk(over ? "to_over" : "to_serve", over ? S_OVER : S_SERVE, p1, p2, srv, 0, !over, 0,
                    over ? (p1 == WS ? 2'd1 : 2'd2) : 2'd0, d));
    if (!over) serve_to_rally(p1, p2, srv);
  endtask
  task automatic point(input logic who2, input logic [3:0] p1, input logic [3:0] p2, input logic over);
    logic [13:0] d0;
    d0 = who2 ? 14'(100 * (p1 - 1) + p2) : 14'(100 * p1 + p2 - 1);
    cyc(0, !who2, who2, mk("miss", S_POINT, p1, p2, who2, 0, 0, 0, 0, d0));
    point_tail(p1, p2, who2, over);
  endtask
  task automatic over_idle(input logic [3:0] p1, input logic [3:0] p2, input logic srv, input logic [1:0] w);
    logic [13:0] d;
    d = 14'(100 * p1 + p2);
    cyc(1, 1, 0, mk("over_ign_m1", S_OVER, p1, p2, srv, 0, 0, 0, w, d));
    cyc(0, 0, 1, mk("over_ign_m2", S_OVER, p1, p2, srv, 0, 0, 0, w, d));
    cyc(1, 0, 0, mk("over_ign_tick", S_OVER, p1, p2, srv, 0, 0, 0, w, d));
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.start_btn = 1'b0;
    bus.miss_p1 = 1'b0;
    bus.miss_p2 = 1'b0;
    tbl.push_back(mv(0, 1, 0, 0, mk("sync1", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mv(0, 1, 0, 0, mk("sync2", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mv(0, 1, 0, 0, mk("serve_entry", S_SERVE, 0, 0, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(mv(0, 1, 0, 0, mk("serve_ld_once", S_SERVE, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int k = 1; k < 8; k++) tbl.push_back(mv(1, 1, 0, 0, mk("serve_tick", S_SERVE, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mv(1, 1, 0, 0, mk("rally_entry", S_RALLY, 0, 0, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(mv(0, 1, 1, 1, mk("double_miss", S_RALLY, 0, 0, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(mv(1, 1, 0, 0, mk("rally_tick", S_RALLY, 0, 0, 0, 1, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++) tbl.push_back(mv(0, 0, 0, 0, mk("rally_btn_lo", S_RALLY, 0, 0, 0, 1, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++) tbl.push_back(mv(0, 1, 0, 0, mk("rally_start_ign", S_RALLY, 0, 0, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(mv(0, 1, 0, 1, mk("miss_p2", S_POINT, 1, 0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(mv(0, 1, 0, 0, mk("disp_lag", S_POINT, 1, 0, 1, 0, 0, 0, 0, 100)));
    tbl.push_back(mv(0, 1, 1, 0, mk("point_miss_ign", S_POINT, 1, 0, 1, 0, 0, 0, 0, 100)));
    repeat (3) @(posedge CLK);
    #1;
    check_now(mk("reset", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    RSTn = 1'b1;
    foreach (tbl[i]) begin
      bus.start_btn = tbl[i].sb;
      cyc(tbl[i].tk, tbl[i].m1, tbl[i].m2, tbl[i].e);
    end
    point_tail(1, 0, 1, 0);
    for (int k = 1; k <= 5; k++) point(0, 1, 4'(k), k == 5);
    over_idle(1, 5, 0, 2);
    bus.start_btn = 1'b0;
    repeat (3) cyc(0, 0, 0, mk("over_btn_lo", S_OVER, 1, 5, 0, 0, 0, 0, 2, 105));
    bus.start_btn = 1'b1;
    repeat (2) cyc(0, 0, 0, mk("over_sync", S_OVER, 1, 5, 0, 0, 0, 0, 2, 105));
    cyc(0, 0, 0, mk("restart", S_SERVE, 0, 0, 0, 0, 1, 0, 0, 105));
    serve_to_rally(0, 0, 0);
    point(1, 1, 0, 0);
    point(1, 2, 0, 0);
    cyc(0, 0, 1, mk("miss_p2_3", S_POINT, 3, 0, 1, 0, 0, 0, 0, 200));
    cyc(1, 0, 0, mk("point_tick1", S_POINT, 3, 0, 1, 0, 0, 1, 0, 300));
    cyc(1, 0, 0, mk("point_tick2", S_POINT, 3, 0, 1, 0, 0, 0, 0, 300));
    cyc(1, 0, 0, mk("point_tick3", S_POINT, 3, 0, 1, 0, 0, 1, 0, 300));
    #2;
    RSTn = 1'b0;
    #1;
    check_now(mk("async_reset", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge CLK);
    #1;
    check_now(mk("reset_hold", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    RSTn = 1'b1;
    cyc(0, 0, 0, mk("post_rst1", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, mk("post_rst2", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, mk("post_rst_start", S_SERVE, 0, 0, 0, 0, 1, 0, 0, 0));
    serve_to_rally(0, 0, 0);
    for (int k = 1; k <= 5; k++) point(0, 0, 4'(k), k == 5);
    over_idle(0, 5, 0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
